// File: rtl/link_turn_ctrl.sv
// Turn-based board exchange controller: LOCAL -> send (with timeout/retry) -> REMOTE -> LOCAL.
// All outputs are registered one cycle after the triggering edge; the link exerts backpressure through peerReady.
module link_turn_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int FIRST_TURN     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sendReq,
    input  logic [255:0] boardIn,
    input  logic         peerReady,
    input  logic         txDone,
    input  logic         rxValid,
    input  logic [255:0] rxBuffer,
    output logic         startTransfer,
    output logic [255:0] sendBuffer,
    output logic [255:0] boardOut,
    output logic         boardValid,
    output logic         myTurn,
    output logic         busy,
    output logic [1:0]   retryCount,
    output logic         timeoutErr,
    output logic         protoErr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX  = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_LOCAL,
        ST_WAIT_PEER,
        ST_WAIT_DONE,
        ST_REMOTE,
        ST_ERROR
    } state_t;

    localparam state_t RESET_STATE = (FIRST_TURN != 0) ? ST_LOCAL : ST_REMOTE;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;

    logic enter;
    logic latch_send;
    logic start_nxt;
    logic take_rx;
    logic retry_inc;
    logic proto_hit;
    logic timer_last;
    logic retry_ok;
    logic in_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        enter      = 1'b0;
        latch_send = 1'b0;
        start_nxt  = 1'b0;
        take_rx    = 1'b0;
        retry_inc  = 1'b0;
        timer_last = (timer == TIMER_LAST);
        retry_ok   = (retryCount < RETRY_MAX);
        in_wait    = (state == ST_WAIT_PEER) || (state == ST_WAIT_DONE);
        // Frames arriving while it is not the peer's turn are dropped and flagged.
        proto_hit  = rxValid && (state != ST_REMOTE);

        case (state)
            ST_LOCAL: begin
                if (sendReq) begin
                    state_nxt  = ST_WAIT_PEER;
                    enter      = 1'b1;
                    latch_send = 1'b1;
                end
            end
            ST_WAIT_PEER, ST_WAIT_DONE: begin
                // The exit event beats a coincident timeout.
                if ((state == ST_WAIT_PEER) && peerReady) begin
                    state_nxt = ST_WAIT_DONE;
                    enter     = 1'b1;
                    start_nxt = 1'b1;
                end else if ((state == ST_WAIT_DONE) && txDone) begin
                    state_nxt = ST_REMOTE;
                    enter     = 1'b1;
                end else if (timer_last) begin
                    enter = 1'b1;
                    if (retry_ok) begin
                        state_nxt = ST_WAIT_PEER;
                        retry_inc = 1'b1;
                    end else begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_REMOTE: begin
                if (rxValid) begin
                    state_nxt = ST_LOCAL;
                    enter     = 1'b1;
                    take_rx   = 1'b1;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = RESET_STATE;
                enter     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer         <= '0;
            sendBuffer    <= '0;
            boardOut      <= '0;
            boardValid    <= 1'b0;
            startTransfer <= 1'b0;
            retryCount    <= 2'd0;
            myTurn        <= (FIRST_TURN != 0);
            busy          <= 1'b0;
            timeoutErr    <= 1'b0;
            protoErr      <= 1'b0;
        end else begin
            if (enter) begin
                timer <= '0;
            end else if (in_wait) begin
                timer <= timer + TW'(1);
            end

            if (latch_send) begin
                sendBuffer <= boardIn;
            end

            if (latch_send) begin
                retryCount <= 2'd0;
            end else if (retry_inc) begin
                retryCount <= retryCount + 2'd1;
            end

            if (take_rx) begin
                boardOut <= rxBuffer;
            end

            boardValid    <= take_rx;
            startTransfer <= start_nxt;
            myTurn        <= (state_nxt == ST_LOCAL);
            busy          <= (state_nxt == ST_WAIT_PEER) || (state_nxt == ST_WAIT_DONE);
            timeoutErr    <= timeoutErr || (state_nxt == ST_ERROR);
            protoErr      <= protoErr || proto_hit;
        end
    end

endmodule

// File: tb/tb_link_turn_ctrl.sv
// Bench for link_turn_ctrl: two instances (local-first T=8/R=2, remote-first T=4/R=0) share stimulus.
// Directed scenarios check constants; a random phase checks both against a turn-level reference model.
module tb_link_turn_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         sendReq;
    logic [255:0] boardIn;
    logic         peerReady;
    logic         txDone;
    logic         rxValid;
    logic [255:0] rxBuffer;

    logic         start_o [2];
    logic [255:0] sbuf_o  [2];
    logic [255:0] bout_o  [2];
    logic         bv_o    [2];
    logic         turn_o  [2];
    logic         busy_o  [2];
    logic [1:0]   retry_o [2];
    logic         terr_o  [2];
    logic         perr_o  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    link_turn_ctrl #(.TIMEOUT_CYCLES(8), .MAX_RETRY(2), .FIRST_TURN(1)) dut (
        .clk(clk), .rst(rst), .sendReq(sendReq), .boardIn(boardIn), .peerReady(peerReady),
        .txDone(txDone), .rxValid(rxValid), .rxBuffer(rxBuffer),
        .startTransfer(start_o[0]), .sendBuffer(sbuf_o[0]), .boardOut(bout_o[0]),
        .boardValid(bv_o[0]), .myTurn(turn_o[0]), .busy(busy_o[0]), .retryCount(retry_o[0]),
        .timeoutErr(terr_o[0]), .protoErr(perr_o[0])
    );

    link_turn_ctrl #(.TIMEOUT_CYCLES(4), .MAX_RETRY(0), .FIRST_TURN(0)) dut_rf (
        .clk(clk), .rst(rst), .sendReq(sendReq), .boardIn(boardIn), .peerReady(peerReady),
        .txDone(txDone), .rxValid(rxValid), .rxBuffer(rxBuffer),
        .startTransfer(start_o[1]), .sendBuffer(sbuf_o[1]), .boardOut(bout_o[1]),
        .boardValid(bv_o[1]), .myTurn(turn_o[1]), .busy(busy_o[1]), .retryCount(retry_o[1]),
        .timeoutErr(terr_o[1]), .protoErr(perr_o[1])
    );

    // Reference model: whose turn it is, how long the current attempt has lasted, and sticky flags.
    // phase: 0 = local may move, 1 = waiting for peer, 2 = waiting for tx, 3 = peer's turn, 4 = dead
    int           m_phase [2];
    int           m_spent [2];
    int           m_retry [2];
    logic [255:0] m_sbuf  [2];
    logic [255:0] m_bout  [2];
    logic         m_start [2];
    logic         m_bv    [2];
    logic         m_perr  [2];

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int tmo   = (k == 0) ? 8 : 4;
            int rmax  = (k == 0) ? 2 : 0;
            bit local_first = (k == 0);
            m_start[k] = 1'b0;
            m_bv[k]    = 1'b0;
            if (rst) begin
                m_phase[k] = local_first ? 0 : 3;
                m_spent[k] = 1;
                m_retry[k] = 0;
                m_sbuf[k]  = '0;
                m_bout[k]  = '0;
                m_perr[k]  = 1'b0;
            end else begin
                if (rxValid && m_phase[k] != 3) m_perr[k] = 1'b1;
                if (m_phase[k] == 0) begin
                    if (sendReq) begin
                        m_sbuf[k]  = boardIn;
                        m_retry[k] = 0;
                        m_phase[k] = 1;
                        m_spent[k] = 1;
                    end
                end else if (m_phase[k] == 1 || m_phase[k] == 2) begin
                    if ((m_phase[k] == 1 && peerReady) || (m_phase[k] == 2 && txDone)) begin
                        m_start[k] = (m_phase[k] == 1);
                        m_phase[k] = m_phase[k] + 1;
                        m_spent[k] = 1;
                    end else if (m_spent[k] >= tmo) begin
                        if (m_retry[k] < rmax) begin
                            m_retry[k] = m_retry[k] + 1;
                            m_phase[k] = 1;
                            m_spent[k] = 1;
                        end else begin
                            m_phase[k] = 4;
                        end
                    end else begin
                        m_spent[k] = m_spent[k] + 1;
                    end
                end else if (m_phase[k] == 3) begin
                    if (rxValid) begin
                        m_bout[k]  = rxBuffer;
                        m_bv[k]    = 1'b1;
                        m_phase[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        sendReq   = 1'b0;
        peerReady = 1'b0;
        txDone    = 1'b0;
        rxValid   = 1'b0;
        boardIn   = '0;
        rxBuffer  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if ({start_o[0], bv_o[0], turn_o[0], busy_o[0], retry_o[0], terr_o[0], perr_o[0]} !== 8'b0010_0000) begin
            errors++;
            $display("FAIL reset_ctl0: got %b expected %b",
                     {start_o[0], bv_o[0], turn_o[0], busy_o[0], retry_o[0], terr_o[0], perr_o[0]}, 8'b0010_0000);
        end
        checks++;
        if ({sbuf_o[0], bout_o[0]} !== 512'd0) begin
            errors++;
            $display("FAIL reset_bufs0: got %h / %h expected 0", sbuf_o[0], bout_o[0]);
        end
        checks++;
        if ({start_o[1], bv_o[1], turn_o[1], busy_o[1], retry_o[1], terr_o[1], perr_o[1]} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctl1: got %b expected %b",
                     {start_o[1], bv_o[1], turn_o[1], busy_o[1], retry_o[1], terr_o[1], perr_o[1]}, 8'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_send_receive();
        logic [255:0] a;
        logic [255:0] b;
        a = rand256();
        b = rand256();
        sendReq = 1'b1;
        boardIn = a;
        step();
        sendReq = 1'b0;
        boardIn = rand256();
        checks++;
        if (sbuf_o[0] !== a || busy_o[0] !== 1'b1 || turn_o[0] !== 1'b0 || start_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL latch: sbuf %h busy %b turn %b start %b expected sbuf %h busy 1 turn 0 start 0",
                     sbuf_o[0], busy_o[0], turn_o[0], start_o[0], a);
        end
        step();
        peerReady = 1'b1;
        step();
        peerReady = 1'b0;
        checks++;
        if (start_o[0] !== 1'b1 || busy_o[0] !== 1'b1 || sbuf_o[0] !== a) begin
            errors++;
            $display("FAIL start_pulse: start %b busy %b expected start 1 busy 1", start_o[0], busy_o[0]);
        end
        step();
        checks++;
        if (start_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL start_single: start %b busy %b expected start 0 busy 1", start_o[0], busy_o[0]);
        end
        txDone = 1'b1;
        step();
        txDone = 1'b0;
        checks++;
        if (turn_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || retry_o[0] !== 2'd0) begin
            errors++;
            $display("FAIL tx_done: turn %b busy %b retry %0d expected 0 0 0", turn_o[0], busy_o[0], retry_o[0]);
        end
        step();
        rxValid  = 1'b1;
        rxBuffer = b;
        step();
        rxValid  = 1'b0;
        rxBuffer = rand256();
        checks++;
        if (bout_o[0] !== b || bv_o[0] !== 1'b1 || turn_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL rx_take: bout %h bv %b turn %b expected bout %h bv 1 turn 1", bout_o[0], bv_o[0], turn_o[0], b);
        end
        step();
        checks++;
        if (bout_o[0] !== b || bv_o[0] !== 1'b0 || turn_o[0] !== 1'b1 || perr_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL rx_after: bout %h bv %b turn %b perr %b expected bout %h bv 0 turn 1 perr 0",
                     bout_o[0], bv_o[0], turn_o[0], perr_o[0], b);
        end
    endtask

    task automatic test_timeout();
        logic [255:0] c;
        c = rand256();
        sendReq = 1'b1;
        boardIn = c;
        step();
        sendReq = 1'b0;
        boardIn = rand256();
        for (int i = 1; i <= 24; i++) begin
            logic [1:0] exp_retry;
            exp_retry = (i >= 24) ? 2'd2 : 2'(i / 8);
            step();
            checks++;
            if (retry_o[0] !== exp_retry || terr_o[0] !== (i == 24) || busy_o[0] !== (i < 24) || sbuf_o[0] !== c) begin
                errors++;
                $display("FAIL timeout_walk[%0d]: retry %0d terr %b busy %b expected retry %0d terr %b busy %b (sbuf ok %b)",
                         i, retry_o[0], terr_o[0], busy_o[0], exp_retry, (i == 24), (i < 24), sbuf_o[0] === c);
            end
        end
        sendReq   = 1'b1;
        peerReady = 1'b1;
        boardIn   = rand256();
        step();
        step();
        sendReq   = 1'b0;
        peerReady = 1'b0;
        checks++;
        if (terr_o[0] !== 1'b1 || turn_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || start_o[0] !== 1'b0 || sbuf_o[0] !== c) begin
            errors++;
            $display("FAIL error_hold: terr %b turn %b busy %b start %b expected 1 0 0 0", terr_o[0], turn_o[0], busy_o[0], start_o[0]);
        end
    endtask

    task automatic test_late_peer();
        logic [255:0] c;
        c   = rand256();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (terr_o[0] !== 1'b0 || turn_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_reset: terr %b turn %b expected terr 0 turn 1", terr_o[0], turn_o[0]);
        end
        sendReq = 1'b1;
        boardIn = c;
        step();
        sendReq = 1'b0;
        repeat (7) step();
        peerReady = 1'b1;
        step();
        peerReady = 1'b0;
        checks++;
        if (start_o[0] !== 1'b1 || retry_o[0] !== 2'd0) begin
            errors++;
            $display("FAIL peer_vs_timeout: start %b retry %0d expected start 1 retry 0", start_o[0], retry_o[0]);
        end
        step();
        repeat (6) step();
        checks++;
        if (retry_o[0] !== 2'd0 || busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_wait: retry %0d busy %b expected retry 0 busy 1", retry_o[0], busy_o[0]);
        end
        step();
        checks++;
        if (retry_o[0] !== 2'd1 || busy_o[0] !== 1'b1 || start_o[0] !== 1'b0 || sbuf_o[0] !== c) begin
            errors++;
            $display("FAIL done_timeout: retry %0d busy %b start %b expected retry 1 busy 1 start 0", retry_o[0], busy_o[0], start_o[0]);
        end
        peerReady = 1'b1;
        step();
        peerReady = 1'b0;
        txDone    = 1'b1;
        step();
        txDone = 1'b0;
        checks++;
        if (retry_o[0] !== 2'd1 || busy_o[0] !== 1'b0 || turn_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL retry_hold: retry %0d busy %b turn %b expected retry 1 busy 0 turn 0", retry_o[0], busy_o[0], turn_o[0]);
        end
    endtask

    task automatic test_proto_err();
        logic [255:0] d;
        logic [255:0] f;
        d = rand256();
        f = rand256();
        rxValid  = 1'b1;
        rxBuffer = d;
        step();
        rxBuffer = rand256();
        step();
        rxValid = 1'b0;
        checks++;
        if (perr_o[0] !== 1'b1 || bout_o[0] !== d || bv_o[0] !== 1'b0 || turn_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL proto_local: perr %b bv %b turn %b bout_ok %b expected perr 1 bv 0 turn 1 bout_ok 1",
                     perr_o[0], bv_o[0], turn_o[0], bout_o[0] === d);
        end
        sendReq  = 1'b1;
        rxValid  = 1'b1;
        boardIn  = f;
        rxBuffer = rand256();
        step();
        sendReq = 1'b0;
        rxValid = 1'b0;
        checks++;
        if (busy_o[0] !== 1'b1 || sbuf_o[0] !== f || bout_o[0] !== d || perr_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL send_and_rx: busy %b perr %b sbuf_ok %b bout_ok %b expected 1 1 1 1",
                     busy_o[0], perr_o[0], sbuf_o[0] === f, bout_o[0] === d);
        end
    endtask

    task automatic test_reset_mid();
        peerReady = 1'b1;
        step();
        peerReady = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({start_o[0], bv_o[0], turn_o[0], busy_o[0], retry_o[0], terr_o[0], perr_o[0]} !== 8'b0010_0000 ||
            sbuf_o[0] !== '0 || bout_o[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid: ctl %b expected %b (bufs zero %b)",
                     {start_o[0], bv_o[0], turn_o[0], busy_o[0], retry_o[0], terr_o[0], perr_o[0]}, 8'b0010_0000,
                     (sbuf_o[0] === '0) && (bout_o[0] === '0));
        end
        sendReq = 1'b1;
        boardIn = rand256();
        step();
        sendReq = 1'b0;
        checks++;
        if (busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_to_local: busy %b expected 1", busy_o[0]);
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(0, 249) == 0);
            sendReq   = ($urandom_range(0, 3) == 0);
            peerReady = ($urandom_range(0, 4) == 0);
            txDone    = ($urandom_range(0, 4) == 0);
            rxValid   = ($urandom_range(0, 9) == 0);
            boardIn   = rand256();
            rxBuffer  = rand256();
            step();
            for (int k = 0; k < 2; k++) begin
                logic [7:0] exp_ctl;
                logic [7:0] got_ctl;
                exp_ctl = {m_start[k], m_bv[k], m_phase[k] == 0, (m_phase[k] == 1) || (m_phase[k] == 2),
                           2'(m_retry[k]), m_phase[k] == 4, m_perr[k]};
                got_ctl = {start_o[k], bv_o[k], turn_o[k], busy_o[k], retry_o[k], terr_o[k], perr_o[k]};
                checks++;
                if (got_ctl !== exp_ctl) begin
                    errors++;
                    $display("FAIL rnd_ctl[%0d] cycle %0d: got %b expected %b", k, cyc, got_ctl, exp_ctl);
                end
                checks++;
                if (sbuf_o[k] !== m_sbuf[k] || bout_o[k] !== m_bout[k]) begin
                    errors++;
                    $display("FAIL rnd_bufs[%0d] cycle %0d: sbuf %h bout %h expected sbuf %h bout %h",
                             k, cyc, sbuf_o[k], bout_o[k], m_sbuf[k], m_bout[k]);
                end
            end
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_spent[k] = 1;
            m_retry[k] = 0;
            m_sbuf[k]  = '0;
            m_bout[k]  = '0;
            m_start[k] = 1'b0;
            m_bv[k]    = 1'b0;
            m_perr[k]  = 1'b0;
        end
        test_reset();
        test_send_receive();
        test_timeout();
        test_late_peer();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
